sysbus_arbiter: RTL and testbench
=================================

# sysbus_arbiter

Two-master arbiter sharing the single Sysbus port of `top` between the instruction-fetch requester (icache) and the memory-stage requester (dcache). It grants ownership round-robin, holds the grant for a whole transaction until the owner signals idle, and muxes the request channel onto the bus. It gates the request-ack and response-valid strobes back to the owner only, and forcibly reclaims the bus from a stalled owner after a watchdog timeout.

## Interface
- `BUS_DATA_WIDTH`, default 64: width of the request/response data.
- `BUS_TAG_WIDTH`, default 13: width of the request/response tag.
- `TIMEOUT`, default 1024: number of idle-bus cycles under one grant before a forced release.
- `clk` in 1: the only clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low.
- `icache_busreq`, `dcache_busreq` in 1: level request for ownership.
- `icache_busidle`, `dcache_busidle` in 1: owner has finished its transaction; honoured only from the current owner.
- `icache_busgrant`, `dcache_busgrant` out 1: registered, one-hot or zero.
- `icache_reqcyc`/`dcache_reqcyc` in 1; `icache_req`/`dcache_req` in BUS_DATA_WIDTH; `icache_reqtag`/`dcache_reqtag` in BUS_TAG_WIDTH: per-master request channel.
- `icache_respack`, `dcache_respack` in 1: per-master response ack.
- `icache_reqack`, `dcache_reqack` out 1: `bus_reqack` gated to the owner.
- `icache_respcyc`, `dcache_respcyc` out 1: `bus_respcyc` gated to the owner. `bus_resp` and `bus_resptag` fan out directly to both masters, with no arbiter path.
- `bus_reqcyc`, `bus_req`, `bus_reqtag`, `bus_respack` out: muxed shared bus outputs.
- `bus_reqack`, `bus_respcyc` in 1: shared bus inputs.
- `timeout_err` out 1: one-cycle pulse on a forced release.

## Operation
- State register: IDLE, OWN_I, OWN_D. Also a `last` bit (last owner), a watchdog counter of $clog2(TIMEOUT+1) bits, and `timeout_err`.
- IDLE:
  - Only one request present: grant that master.
  - Both requests present: grant the master that is not `last`.
  - No request: stay in IDLE.
- OWN_x:
  - The owner's request channel drives the bus: `bus_reqcyc`/`req`/`reqtag`/`respack` = owner's signals.
  - The owner receives `reqack`/`respcyc`. The non-owner receives 0 on both.
- Release from OWN_x to IDLE when either condition holds:
  - the owner's busidle is sampled high; or
  - the watchdog reaches TIMEOUT. This also pulses `timeout_err`.
  - On release, `last` ← x.
- Watchdog:
  - Clears on entry to OWN_x.
  - Clears in any cycle with `bus_reqcyc`, `bus_reqack`, `bus_respcyc` or `bus_respack` high.
  - Otherwise increments, and saturates at TIMEOUT.
- The owner's busreq deasserting without busidle does not release the grant; only busidle or the timeout releases it.
- The non-owner's busidle is ignored.
- In IDLE all bus outputs are 0, and both reqack/respcyc outputs are 0.
- Reset (asserted low, at any time, including mid-transaction):
  - state = IDLE, `last` = dcache (so icache wins the first tie).
  - Counter = 0.
  - All grants, bus outputs, gated strobes and `timeout_err` are 0 immediately (asynchronous), regardless of in-flight bus activity.

## Timing
- Grant latency: a request sampled at edge N gives busgrant high after edge N. Bus muxing follows the registered state in the same cycle.
- Release: busidle sampled at edge M makes the grant low after edge M. The bus outputs are 0 in cycle M+1.
- The earliest regrant to either master is after edge M+1. There is exactly one dead cycle between owners.
- Ack/response gating is combinational from the registered state: zero added latency on the reqack/respcyc paths.
- `timeout_err`: high for exactly the one cycle following the release edge.
- If busidle and the timeout coincide on the same edge, the release counts as normal and `timeout_err` stays 0.
- Request muxing is combinational from registered state plus the master inputs: master→bus path has zero latency.

## Test plan
- **Reset then single master:** assert `dcache_busreq` only → `dcache_busgrant`=1 one edge later. Drive `dcache_req`=64'hDEAD_BEEF, tag 13'h5 → `bus_req`=64'hDEAD_BEEF, `bus_reqtag`=13'h5. `icache_reqack` stays 0 while `bus_reqack`=1.
- **Tie after reset:** both request at the same edge → icache granted. On icache busidle → one dead cycle → dcache granted. A second tie goes to the master not granted last.
- **Response gating:** while dcache owns the bus, `bus_respcyc`=1, `bus_resptag`=13'h1A → `dcache_respcyc`=1, `icache_respcyc`=0. `bus_respack` follows `dcache_respack`.
- **Watchdog:** TIMEOUT=8; grant icache, then hold all bus strobes low → release after 8 idle cycles, `timeout_err` pulses for exactly 1 cycle. A bus strobe at cycle 5 restarts the count.
- **Busidle discipline:** the non-owner asserts busidle → no change. The owner drops busreq without busidle → grant held.
- **Reset mid-transaction:** assert reset low while dcache has `bus_reqcyc`=1 → all outputs are 0 asynchronously. After deassertion with both requesting → icache granted first.

Source files
------------

// File: rtl/sysbus_arbiter_if.sv
// Sysbus request/response handshake channel.
//   master modport: drives reqcyc/req/reqtag/respack, receives reqack/respcyc.
//   slave modport : the mirror image.
// One instance per cache-side master port and one for the shared bus port.
interface sysbus_arbiter_if #(
   parameter int unsigned BUS_DATA_WIDTH = 64,
   parameter int unsigned BUS_TAG_WIDTH  = 13
);
   logic                      reqcyc;
   logic [BUS_DATA_WIDTH-1:0] req;
   logic [BUS_TAG_WIDTH-1:0]  reqtag;
   logic                      respack;
   logic                      reqack;
   logic                      respcyc;

   modport master (
      output reqcyc, req, reqtag, respack,
      input  reqack, respcyc
   );

   modport slave (
      input  reqcyc, req, reqtag, respack,
      output reqack, respcyc
   );
endinterface

// File: rtl/sysbus_arbiter.sv
// Two-master round-robin arbiter for the shared Sysbus port (icache vs dcache).
// The grant is held for a whole transaction until the owner raises busidle, or
// until a watchdog sees TIMEOUT consecutive cycles with no bus strobe.
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_{icache,dcache}_busreq        level ownership requests
//   i_{icache,dcache}_busidle       owner finished (ignored from the non-owner)
//   o_{icache,dcache}_busgrant      registered grants, one-hot or zero
//   io_icache, io_dcache            per-master request channels (slave side)
//   io_bus                          shared bus channel (master side)
//   o_timeout_err                   one-cycle pulse on a forced release
// bus_resp/bus_resptag go straight to both masters and do not pass through here.
module sysbus_arbiter #(
   parameter int unsigned BUS_DATA_WIDTH = 64,
   parameter int unsigned BUS_TAG_WIDTH  = 13,
   parameter int unsigned TIMEOUT        = 1024
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_icache_busreq,
   input  logic              i_dcache_busreq,
   input  logic              i_icache_busidle,
   input  logic              i_dcache_busidle,
   output logic              o_icache_busgrant,
   output logic              o_dcache_busgrant,
   sysbus_arbiter_if.slave   io_icache,
   sysbus_arbiter_if.slave   io_dcache,
   sysbus_arbiter_if.master  io_bus,
   output logic              o_timeout_err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StOwnI, StOwnD} state_e;

   state_e           r_state;
   logic             r_last;        // 1: dcache owned last, 0: icache owned last
   logic [CNT_W-1:0] r_cnt;
   logic             r_icache_grant;
   logic             r_dcache_grant;
   logic             r_timeout_err;

   logic                      w_reqcyc;
   logic [BUS_DATA_WIDTH-1:0] w_req;
   logic [BUS_TAG_WIDTH-1:0]  w_reqtag;
   logic                      w_respack;
   logic                      w_bus_active;
   logic                      w_wdog_fire;

   // Request mux and strobe gating follow the registered state only.
   always_comb begin
      w_reqcyc          = 1'b0;
      w_req             = '0;
      w_reqtag          = '0;
      w_respack         = 1'b0;
      io_icache.reqack  = 1'b0;
      io_icache.respcyc = 1'b0;
      io_dcache.reqack  = 1'b0;
      io_dcache.respcyc = 1'b0;
      case (r_state)
         StOwnI: begin
            w_reqcyc          = io_icache.reqcyc;
            w_req             = io_icache.req;
            w_reqtag          = io_icache.reqtag;
            w_respack         = io_icache.respack;
            io_icache.reqack  = io_bus.reqack;
            io_icache.respcyc = io_bus.respcyc;
         end
         StOwnD: begin
            w_reqcyc          = io_dcache.reqcyc;
            w_req             = io_dcache.req;
            w_reqtag          = io_dcache.reqtag;
            w_respack         = io_dcache.respack;
            io_dcache.reqack  = io_bus.reqack;
            io_dcache.respcyc = io_bus.respcyc;
         end
         default: ;
      endcase
   end

   assign io_bus.reqcyc  = w_reqcyc;
   assign io_bus.req     = w_req;
   assign io_bus.reqtag  = w_reqtag;
   assign io_bus.respack = w_respack;

   assign w_bus_active = w_reqcyc | w_respack | io_bus.reqack | io_bus.respcyc;
   // Fires on the edge that would bring the idle count up to TIMEOUT.
   assign w_wdog_fire  = !w_bus_active && (r_cnt >= CNT_LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state        <= StIdle;
         r_last         <= 1'b1;
         r_cnt          <= '0;
         r_icache_grant <= 1'b0;
         r_dcache_grant <= 1'b0;
         r_timeout_err  <= 1'b0;
      end else begin
         r_timeout_err <= 1'b0;
         if (w_bus_active) begin
            r_cnt <= '0;
         end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
         end
         case (r_state)
            StIdle: begin
               if (i_icache_busreq && (!i_dcache_busreq || r_last)) begin
                  r_state        <= StOwnI;
                  r_icache_grant <= 1'b1;
                  r_cnt          <= '0;
               end else if (i_dcache_busreq) begin
                  r_state        <= StOwnD;
                  r_dcache_grant <= 1'b1;
                  r_cnt          <= '0;
               end
            end
            StOwnI: begin
               if (i_icache_busidle || w_wdog_fire) begin
                  r_state        <= StIdle;
                  r_icache_grant <= 1'b0;
                  r_last         <= 1'b0;
                  // A coincident busidle makes it an ordinary release.
                  r_timeout_err  <= !i_icache_busidle;
               end
            end
            StOwnD: begin
               if (i_dcache_busidle || w_wdog_fire) begin
                  r_state        <= StIdle;
                  r_dcache_grant <= 1'b0;
                  r_last         <= 1'b1;
                  r_timeout_err  <= !i_dcache_busidle;
               end
            end
            default: begin
               r_state        <= StIdle;
               r_icache_grant <= 1'b0;
               r_dcache_grant <= 1'b0;
            end
         endcase
      end
   end

   assign o_icache_busgrant = r_icache_grant;
   assign o_dcache_busgrant = r_dcache_grant;
   assign o_timeout_err     = r_timeout_err;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter with TIMEOUT = 8.
module tb_sysbus_arbiter;

   localparam int unsigned DW = 64;
   localparam int unsigned TW = 13;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic icache_busreq = 1'b0, dcache_busreq = 1'b0;
   logic icache_busidle = 1'b0, dcache_busidle = 1'b0;
   logic icache_busgrant, dcache_busgrant, timeout_err;

   int n_cmp = 0;
   int n_err = 0;

   sysbus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) icache_if ();
   sysbus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) dcache_if ();
   sysbus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) bus_if ();

   sysbus_arbiter #(
      .BUS_DATA_WIDTH(DW),
      .BUS_TAG_WIDTH (TW),
      .TIMEOUT       (8)
   ) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_icache_busreq  (icache_busreq),
      .i_dcache_busreq  (dcache_busreq),
      .i_icache_busidle (icache_busidle),
      .i_dcache_busidle (dcache_busidle),
      .o_icache_busgrant(icache_busgrant),
      .o_dcache_busgrant(dcache_busgrant),
      .io_icache        (icache_if),
      .io_dcache        (dcache_if),
      .io_bus           (bus_if),
      .o_timeout_err    (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      icache_if.reqcyc  = 1'b0;
      icache_if.req     = '0;
      icache_if.reqtag  = '0;
      icache_if.respack = 1'b0;
      dcache_if.reqcyc  = 1'b0;
      dcache_if.req     = '0;
      dcache_if.reqtag  = '0;
      dcache_if.respack = 1'b0;
      bus_if.reqack     = 1'b0;
      bus_if.respcyc    = 1'b0;

      // Reset
      #2 rst_n = 1'b0;
      #1;
      check("rst_igrant", icache_busgrant, 0);
      check("rst_dgrant", dcache_busgrant, 0);
      check("rst_reqcyc", bus_if.reqcyc, 0);
      check("rst_terr", timeout_err, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Single master: dcache
      dcache_busreq = 1'b1;
      tick();
      check("d_grant", dcache_busgrant, 1);
      check("d_igrant", icache_busgrant, 0);
      dcache_if.req    = 64'hDEAD_BEEF;
      dcache_if.reqtag = 13'h5;
      dcache_if.reqcyc = 1'b1;
      bus_if.reqack    = 1'b1;
      #1;
      check("d_bus_req", bus_if.req, 64'hDEAD_BEEF);
      check("d_bus_tag", bus_if.reqtag, 13'h5);
      check("d_bus_cyc", bus_if.reqcyc, 1);
      check("d_ireqack", icache_if.reqack, 0);
      check("d_dreqack", dcache_if.reqack, 1);

      // Response gating
      bus_if.respcyc    = 1'b1;
      dcache_if.respack = 1'b1;
      #1;
      check("d_drespcyc", dcache_if.respcyc, 1);
      check("d_irespcyc", icache_if.respcyc, 0);
      check("d_respack", bus_if.respack, 1);

      // Busidle discipline
      icache_busidle = 1'b1;
      tick();
      check("nonowner_idle", dcache_busgrant, 1);
      icache_busidle = 1'b0;
      dcache_busreq  = 1'b0;
      tick();
      check("owner_dropreq", dcache_busgrant, 1);
      dcache_if.reqcyc  = 1'b0;
      dcache_if.respack = 1'b0;
      bus_if.reqack     = 1'b0;
      bus_if.respcyc    = 1'b0;
      dcache_busidle    = 1'b1;
      tick();
      dcache_busidle = 1'b0;
      check("d_release", dcache_busgrant, 0);
      check("idle_bus_req", bus_if.req, 0);
      check("idle_terr", timeout_err, 0);

      // Ties: last owner was dcache
      icache_busreq = 1'b1;
      dcache_busreq = 1'b1;
      tick();
      check("tie1_i", icache_busgrant, 1);
      check("tie1_d", dcache_busgrant, 0);
      icache_busidle = 1'b1;
      tick();
      icache_busidle = 1'b0;
      check("dead_i", icache_busgrant, 0);
      check("dead_d", dcache_busgrant, 0);
      tick();
      check("tie2_d", dcache_busgrant, 1);
      check("tie2_i", icache_busgrant, 0);
      dcache_busidle = 1'b1;
      tick();
      dcache_busidle = 1'b0;
      dcache_busreq  = 1'b0;
      tick();
      check("tie3_i", icache_busgrant, 1);

      // Watchdog: icache granted at edge G; strobe on edge G+5 restarts the count
      icache_busreq = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      icache_if.reqcyc = 1'b1;
      tick();
      icache_if.reqcyc = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      check("wd_held", icache_busgrant, 1);
      check("wd_noerr", timeout_err, 0);
      tick();
      check("wd_release", icache_busgrant, 0);
      check("wd_pulse", timeout_err, 1);
      tick();
      check("wd_pulse_end", timeout_err, 0);

      // Busidle coinciding with the timeout is an ordinary release
      icache_busreq = 1'b1;
      tick();
      icache_busreq = 1'b0;
      check("co_grant", icache_busgrant, 1);
      for (int i = 0; i < 7; i++) tick();
      icache_busidle = 1'b1;
      tick();
      icache_busidle = 1'b0;
      check("co_release", icache_busgrant, 0);
      check("co_noerr", timeout_err, 0);

      // Reset mid-transaction
      dcache_busreq = 1'b1;
      tick();
      dcache_if.reqcyc = 1'b1;
      bus_if.reqack    = 1'b1;
      #1;
      check("mid_cyc", bus_if.reqcyc, 1);
      rst_n = 1'b0;
      #1;
      check("mid_dgrant", dcache_busgrant, 0);
      check("mid_cyc0", bus_if.reqcyc, 0);
      check("mid_req0", bus_if.req, 0);
      check("mid_dreqack", dcache_if.reqack, 0);
      check("mid_terr", timeout_err, 0);
      dcache_if.reqcyc = 1'b0;
      bus_if.reqack    = 1'b0;
      icache_busreq    = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      check("post_i", icache_busgrant, 1);
      check("post_d", dcache_busgrant, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
